instr_encoder: RTL
==================

# instr_encoder

RV32I instruction encoder and instruction-memory loader: the inverse of the main opcode controller. It accepts instruction fields (format, opcode, registers, functs, immediate) over a valid/ready handshake, packs them into a 32-bit instruction word and writes it into instruction memory at sequential word addresses. Illegal opcode/format combinations are rejected with an error pulse. It sits beside the single-cycle core and serves as the boot/test program loader.

## Interface
- ADDR_W, 8, instruction-memory word-address width; DEPTH = 2**ADDR_W
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; loads start_addr, clears count, enters READY
- stop  in  1  one-cycle pulse; READY -> IDLE
- start_addr  in  ADDR_W  first word address of the load
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6-7 illegal
- opcode  in  7  major opcode
- rd, rs1, rs2  in  5 each  register indices
- funct3  in  3; funct7  in  7
- imm  in  32  immediate, byte offset for B/J, full 32-bit value for U
- imem_we  out  1  write strobe, held until imem_ack
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- imem_ack  in  1  memory accepted the write this cycle
- err  out  1  one-cycle pulse: bundle rejected
- full  out  1  last word (DEPTH-1) written; loader halted
- count  out  ADDR_W+1  words written since start

## Operation
- States: IDLE, READY, WRITE, FULL.
- IDLE: in_ready=0. start -> READY, addr<=start_addr, count<=0.
- READY: in_ready=1. stop -> IDLE (stop wins over in_valid). in_valid: encode; if legal, register word -> WRITE; if illegal, err=1 next cycle, bundle dropped, stay READY.
- WRITE: in_ready=0, imem_we=1, addr/wdata stable. On imem_ack: count+1; if addr==DEPTH-1 -> FULL, else addr+1 -> READY.
- FULL: full=1, in_ready=0; start -> READY with new start_addr, full cleared. stop -> IDLE.
- start in WRITE ignored; start in READY restarts (addr reload, count clear).
- Legal opcodes: R 0110011; I 0010011 or 0000011; S 0100011; B 1100011; U 0110111 or 0010111; J 1101111. B/J additionally require imm[0]=0.
- Packing: R {funct7,rs2,rs1,funct3,rd,op}; I {imm[11:0],rs1,funct3,rd,op}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}. Unused imm bits ignored, no range check.

## Timing
- Reset (async): state IDLE; in_ready, imem_we, err, full = 0; imem_addr, imem_wdata, count = 0. Reset mid-WRITE drops imem_we immediately.
- Accept at edge N (in_valid & in_ready) -> imem_we high cycle N+1, wdata registered.
- imem_ack in first WRITE cycle -> in_ready high cycle N+2; minimum 2 cycles per word.
- imem_ack sampled only while imem_we=1.
- err: registered, high exactly one cycle after the rejected accept.
- Address never wraps: write to DEPTH-1 ends in FULL.

## Structure
- Package rv_isa_pkg: opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL), fmt enum, loader state enum; shared with controller.
- Sub-module instr_pack: purely combinational packer plus legality check (word, legal); FSM and counters in instr_encoder.

## Test plan
- R add x3,x1,x2 (funct7=0,funct3=0), ack immediate -> imem_wdata=0x002081B3 at start_addr, count=1.
- I addi x1,x0,5; S sw x2,8(x1) -> 0x00500093 then 0x0020A423 at consecutive addresses.
- J jal x1,8 -> 0x008000EF; U lui x5,0x12345000 -> 0x123452B7; ack delayed 3 cycles -> imem_we/addr/wdata stable throughout.
- fmt=R, opcode=1100011 -> err one cycle, no imem_we, count unchanged; B with imm=3 -> err.
- ADDR_W=2, start_addr=2, two legal words -> writes at 2,3, full=1, in_ready=0; start -> full clears.
- rst_n low during WRITE -> imem_we drops asynchronously, all outputs 0, IDLE after release.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants and loader types, shared between the encoder and the main controller.
package rv_isa_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Encodings 6 and 7 are deliberately left out; the packer treats them as illegal.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READY,
    ST_WRITE,
    ST_FULL
  } ld_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with opcode/format legality check.
module instr_pack
  import rv_isa_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  // Pack fields per format; B/J offsets must be halfword aligned.
  always_comb begin
    word  = 32'h0;
    legal = 1'b0;
    case (fmt)
      FMT_R: begin
        word  = {funct7, rs2, rs1, funct3, rd, opcode};
        legal = (opcode == OP_R);
      end
      FMT_I: begin
        word  = {imm[11:0], rs1, funct3, rd, opcode};
        legal = (opcode == OP_I) || (opcode == OP_LOAD);
      end
      FMT_S: begin
        word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        legal = (opcode == OP_STORE);
      end
      FMT_B: begin
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        legal = (opcode == OP_BRANCH) && !imm[0];
      end
      FMT_U: begin
        word  = {imm[31:12], rd, opcode};
        legal = (opcode == OP_LUI) || (opcode == OP_AUIPC);
      end
      FMT_J: begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        legal = (opcode == OP_JAL) && !imm[0];
      end
      default: begin
        word  = 32'h0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder / instruction-memory loader.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | loader off, bundles not accepted
//   READY    | in_ready high, waiting for a field bundle
//   WRITE    | imem_we held with stable addr/wdata until imem_ack
//   FULL     | word DEPTH-1 written, halted until start or stop
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ack,
  output logic              err,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  ld_state_e   state;
  logic [31:0] pk_word;
  logic        pk_legal;

  instr_pack u_pack (
    .fmt    (fmt),
    .opcode (opcode),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .funct7 (funct7),
    .imm    (imm),
    .word   (pk_word),
    .legal  (pk_legal)
  );

  // Loader FSM; all handshake and memory-side outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      err        <= 1'b0;
      full       <= 1'b0;
      count      <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_READY;
            in_ready  <= 1'b1;
            imem_addr <= start_addr;
            count     <= '0;
          end
        end
        ST_READY: begin
          if (stop) begin
            state    <= ST_IDLE;
            in_ready <= 1'b0;
          end else begin
            // A restart coinciding with a bundle still accepts it, at the new address.
            if (start) begin
              imem_addr <= start_addr;
              count     <= '0;
            end
            if (in_valid) begin
              if (pk_legal) begin
                state      <= ST_WRITE;
                in_ready   <= 1'b0;
                imem_we    <= 1'b1;
                imem_wdata <= pk_word;
              end else begin
                err <= 1'b1;
              end
            end
          end
        end
        ST_WRITE: begin
          if (imem_ack) begin
            imem_we <= 1'b0;
            count   <= count + 1'b1;
            if (imem_addr == LAST_ADDR) begin
              state <= ST_FULL;
              full  <= 1'b1;
            end else begin
              state     <= ST_READY;
              in_ready  <= 1'b1;
              imem_addr <= imem_addr + 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (stop) begin
            state <= ST_IDLE;
            full  <= 1'b0;
          end else if (start) begin
            state     <= ST_READY;
            full      <= 1'b0;
            in_ready  <= 1'b1;
            imem_addr <= start_addr;
            count     <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
